serial_byte_enqueuer: RTL and testbench

- Upstream feeder for the 8-entry byte queue.
- Collects a serial bit stream, MSB first, into bytes.
- Presents each completed byte with a one-cycle enqueue strobe, then spaces strobes so the queue FSM can return to its waiting state.
- Drops bytes when the queue reports full and counts the drops.

---
 rtl/fila_pkg.sv | 13 +
 rtl/sat_counter8.sv | 25 ++
 rtl/serial_byte_enqueuer.sv | 147 ++++++++++++++
 tb/tb_serial_byte_enqueuer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
// fila_pkg: shared types, constants and helpers for the byte-queue feeder.
//   enq_state_e     : enqueuer FSM states (COLLECT, PUSH, HOLD)
//   DEF_QUEUE_DEPTH : default queue capacity
//   DATA_W          : byte width
//   sat_inc8        : saturating increment for 8-bit counters
package fila_pkg;
    typedef enum logic [1:0] {COLLECT, PUSH, HOLD} enq_state_e;
    localparam int DEF_QUEUE_DEPTH = 8;
    localparam int DATA_W = 8;
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/sat_counter8.sv
// sat_counter8: 8-bit event counter that sticks at 255.
//   clk   in  : clock, rising edge
//   rst_n in  : asynchronous active-low reset
//   inc   in  : count one event this cycle
//   clear in  : synchronous clear (wins over inc)
//   count out : current count
module sat_counter8
    import fila_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clear,
    output logic [7:0] count
);
    logic [7:0] count_q, count_d;

    always_comb count_d = clear ? 8'd0 : inc ? sat_inc8(count_q) : count_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count_q <= 8'd0;
        else        count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/serial_byte_enqueuer.sv
// serial_byte_enqueuer: assembles an MSB-first bit stream into bytes and pushes them to the byte queue.
//   clock_10KHz    in  : clock, rising edge
//   reset          in  : asynchronous active-low reset
//   bit_in         in  : serial data bit
//   bit_valid_in   in  : bit_in is sampled this edge
//   frame_abort_in in  : discard the partially assembled byte
//   len_in         in  : current queue occupancy
//   data_out       out : last pushed byte
//   enqueue_out    out : one-cycle push strobe
//   busy_out       out : push or hold-off in progress
//   bit_count_out  out : bits collected toward the current frame
//   drop_count_out out : dropped bytes, saturating
//   parity_err_out out : bad-parity frames, saturating (SERIAL_PARITY_CHECK_EN only)
// Build option: define SERIAL_PARITY_CHECK_EN for 9-bit frames with even parity.
module serial_byte_enqueuer
    import fila_pkg::*;
#(
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int LEN_W       = 4,
    parameter int HOLDOFF     = 2
) (
    input  logic             clock_10KHz,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid_in,
    input  logic             frame_abort_in,
    input  logic [LEN_W-1:0] len_in,
`ifdef SERIAL_PARITY_CHECK_EN
    output logic [7:0]       parity_err_out,
`endif
    output logic [7:0]       data_out,
    output logic             enqueue_out,
    output logic             busy_out,
    output logic [3:0]       bit_count_out,
    output logic [7:0]       drop_count_out
);
`ifdef SERIAL_PARITY_CHECK_EN
    localparam int FRAME_BITS = 9;
    // The shifter only needs to hold the bits that precede the final one.
    localparam int SHIFT_W = 8;
`else
    localparam int FRAME_BITS = 8;
    localparam int SHIFT_W = 7;
`endif
    localparam logic [3:0]     LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [3:0]     HOLD_LD  = 4'(HOLDOFF);
    localparam logic [LEN_W:0] DEPTH_L  = (LEN_W + 1)'(QUEUE_DEPTH);

    enq_state_e          state_q, state_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [3:0]          hold_q, hold_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   frame_byte;
    logic                complete, parity_ok, accept, drop_inc;

`ifdef SERIAL_PARITY_CHECK_EN
    logic                perr_inc;
    assign frame_byte = shift_q;
    assign parity_ok  = ~^{shift_q, bit_in};
`else
    assign frame_byte = {shift_q, bit_in};
    assign parity_ok  = 1'b1;
`endif

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        complete  = 1'b0;
        // Abort outranks a valid bit on the same edge.
        if (frame_abort_in) begin
            shift_d   = '0;
            bit_cnt_d = 4'd0;
        end else if (bit_valid_in) begin
            shift_d   = {shift_q[SHIFT_W-2:0], bit_in};
            complete  = (bit_cnt_q == LAST_BIT);
            bit_cnt_d = complete ? 4'd0 : bit_cnt_q + 4'd1;
        end
    end

    // Occupancy matters only at the completion edge; a push already scheduled is never revoked.
    assign accept   = complete && parity_ok && state_q == COLLECT && {1'b0, len_in} < DEPTH_L;
    assign drop_inc = complete && parity_ok && !accept;
`ifdef SERIAL_PARITY_CHECK_EN
    assign perr_inc = complete && !parity_ok;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        case (state_q)
            COLLECT: begin
                data_d  = accept ? frame_byte : data_q;
                state_d = accept ? PUSH : COLLECT;
            end
            PUSH: begin
                state_d = HOLD;
                hold_d  = HOLD_LD;
            end
            HOLD: begin
                // Leave once the counter reaches zero, giving HOLDOFF idle cycles.
                hold_d  = hold_q - 4'd1;
                state_d = (hold_q == 4'd1) ? COLLECT : HOLD;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clock_10KHz or negedge reset)
        if (!reset) begin
            state_q   <= COLLECT;
            shift_q   <= '0;
            bit_cnt_q <= 4'd0;
            hold_q    <= 4'd0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            hold_q    <= hold_d;
            data_q    <= data_d;
        end

    sat_counter8 u_drop_cnt (
        .clk   (clock_10KHz),
        .rst_n (reset),
        .inc   (drop_inc),
        .clear (1'b0),
        .count (drop_count_out)
    );

`ifdef SERIAL_PARITY_CHECK_EN
    sat_counter8 u_perr_cnt (
        .clk   (clock_10KHz),
        .rst_n (reset),
        .inc   (perr_inc),
        .clear (1'b0),
        .count (parity_err_out)
    );
`endif

    assign data_out      = data_q;
    assign enqueue_out   = (state_q == PUSH);
    assign busy_out      = (state_q != COLLECT);
    assign bit_count_out = bit_cnt_q;
endmodule

// File: tb/tb_serial_byte_enqueuer.sv
// tb_serial_byte_enqueuer: directed bench; instance 0 uses HOLDOFF=2, instance 1 uses HOLDOFF=15, both fed the same stream.
module tb_serial_byte_enqueuer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid_in = 1'b0;
    logic       frame_abort_in = 1'b0;
    logic [3:0] len_in = 4'd0;

    logic [7:0] data_w [2];
    logic       enq_w  [2];
    logic       busy_w [2];
    logic [3:0] bc_w   [2];
    logic [7:0] drop_w [2];
`ifdef SERIAL_PARITY_CHECK_EN
    logic [7:0] perr_w [2];
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #50 clk = ~clk;

    serial_byte_enqueuer #(.QUEUE_DEPTH(8), .LEN_W(4), .HOLDOFF(2)) u_a (
        .clock_10KHz(clk), .reset(rst_n), .bit_in(bit_in), .bit_valid_in(bit_valid_in),
        .frame_abort_in(frame_abort_in), .len_in(len_in),
`ifdef SERIAL_PARITY_CHECK_EN
        .parity_err_out(perr_w[0]),
`endif
        .data_out(data_w[0]), .enqueue_out(enq_w[0]), .busy_out(busy_w[0]),
        .bit_count_out(bc_w[0]), .drop_count_out(drop_w[0]));

    serial_byte_enqueuer #(.QUEUE_DEPTH(8), .LEN_W(4), .HOLDOFF(15)) u_b (
        .clock_10KHz(clk), .reset(rst_n), .bit_in(bit_in), .bit_valid_in(bit_valid_in),
        .frame_abort_in(frame_abort_in), .len_in(len_in),
`ifdef SERIAL_PARITY_CHECK_EN
        .parity_err_out(perr_w[1]),
`endif
        .data_out(data_w[1]), .enqueue_out(enq_w[1]), .busy_out(busy_w[1]),
        .bit_count_out(bc_w[1]), .drop_count_out(drop_w[1]));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: bits gathered in a queue; each instance remembers the edge of its last accepted push
    // and is busy for that cycle plus its hold-off window.
    int   cyc = 0;
    bit   bitq [$];
    int   push_e [2] = '{-1000, -1000};
    int   mdata  [2] = '{0, 0};
    int   mdrop  [2] = '{0, 0};
    int   holdv  [2] = '{2, 15};
    int   last_strobe = -1;

    task automatic model_reset();
        bitq.delete();
        for (int d = 0; d < 2; d++) begin
            push_e[d] = -1000;
            mdata[d]  = 0;
            mdrop[d]  = 0;
        end
        last_strobe = -1;
    endtask

    task automatic model_step();
        logic [7:0] b;
        bit busy_prev;
        cyc++;
        if (frame_abort_in) bitq.delete();
        else if (bit_valid_in) begin
            bitq.push_back(bit_in);
            if (bitq.size() == 8) begin
                b = 8'd0;
                for (int i = 0; i < 8; i++) b = {b[6:0], bitq[i]};
                bitq.delete();
                for (int d = 0; d < 2; d++) begin
                    busy_prev = (cyc - 1 >= push_e[d]) && (cyc - 1 <= push_e[d] + holdv[d]);
                    if (!busy_prev && len_in < 8) begin
                        push_e[d] = cyc;
                        mdata[d]  = b;
                    end else if (mdrop[d] < 255) mdrop[d]++;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) model_reset();
        else model_step();

    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("enq[%0d]", d), enq_w[d], (cyc == push_e[d]) ? 1 : 0);
            chk($sformatf("busy[%0d]", d), busy_w[d], (cyc >= push_e[d] && cyc <= push_e[d] + holdv[d]) ? 1 : 0);
            chk($sformatf("data[%0d]", d), data_w[d], mdata[d]);
            chk($sformatf("bitcnt[%0d]", d), bc_w[d], bitq.size());
            chk($sformatf("drop[%0d]", d), drop_w[d], mdrop[d]);
        end
        if (rst_n && enq_w[0]) begin
            if (last_strobe >= 0) chk("strobe_spacing", (cyc - last_strobe >= 3) ? 1 : 0, 1);
            last_strobe = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_valid_in   = 1'b0;
            frame_abort_in = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic [3:0] len);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            bit_in         = b[i];
            bit_valid_in   = 1'b1;
            frame_abort_in = 1'b0;
            len_in         = len;
        end
    endtask

    task automatic at_edge();
        @(posedge clk);
        #3;
    endtask

    initial begin
        repeat (3) at_edge();
        chk("reset_data", data_w[0], 0);
        chk("reset_enq", enq_w[0], 0);
        chk("reset_busy", busy_w[1], 0);
        chk("reset_drop", drop_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        send_bits(8'hA5, 8, 4'd0);
        at_edge();
        chk("a5_enq", enq_w[0], 1);
        chk("a5_data", data_w[0], 8'hA5);
        chk("a5_bitcnt", bc_w[0], 0);
        idle(3);
        at_edge();
        chk("a5_held", data_w[0], 8'hA5);
        chk("a5_enq_low", enq_w[0], 0);
        idle(20);

        send_bits(8'h01, 8, 4'd0);
        send_bits(8'hFF, 8, 4'd0);
        at_edge();
        chk("ff_enq_a", enq_w[0], 1);
        chk("ff_enq_b", enq_w[1], 0);
        idle(20);
        chk("b2b_data_a", data_w[0], 8'hFF);
        chk("b2b_drop_a", drop_w[0], 0);
        chk("overrun_drop_b", drop_w[1], 1);
        chk("overrun_data_b", data_w[1], 8'h01);

        send_bits(8'h3C, 8, 4'd8);
        at_edge();
        chk("full_enq", enq_w[0], 0);
        idle(3);
        chk("full_drop_a", drop_w[0], 1);
        chk("full_data_a", data_w[0], 8'hFF);
        chk("full_drop_b", drop_w[1], 2);
        idle(5);

        send_bits(8'hF8, 5, 4'd0);
        at_edge();
        chk("partial_bitcnt", bc_w[0], 5);
        @(negedge clk);
        bit_in = 1'b1;
        bit_valid_in = 1'b1;
        frame_abort_in = 1'b1;
        at_edge();
        chk("abort_bitcnt", bc_w[0], 0);
        send_bits(8'h0F, 8, 4'd0);
        at_edge();
        chk("abort_enq", enq_w[0], 1);
        chk("abort_data_a", data_w[0], 8'h0F);
        chk("abort_data_b", data_w[1], 8'h0F);
        idle(20);

        send_bits(8'h00, 8, 4'd9);
        send_bits(8'h00, 8, 4'd15);
        idle(3);
        chk("drops3", drop_w[0], 3);
        send_bits(8'h77, 8, 4'd0);
        at_edge();
        chk("pre_reset_enq", enq_w[0], 1);
        @(negedge clk);
        at_edge();
        chk("mid_hold_busy", busy_w[0], 1);
        @(negedge clk);
        rst_n = 1'b0;
        bit_valid_in = 1'b0;
        #1;
        chk("async_busy", busy_w[0], 0);
        chk("async_data", data_w[0], 0);
        chk("async_drop", drop_w[0], 0);
        chk("async_enq", enq_w[1], 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_bits(8'h5A, 8, 4'd0);
        at_edge();
        chk("post_reset_enq", enq_w[0], 1);
        chk("post_reset_data", data_w[0], 8'h5A);
        chk("post_reset_drop", drop_w[0], 0);
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
